// File: rtl/cbd516_timer.sv
// cbd516_timer: 16-bit loadable down-counting interval timer.
// Supports one-shot and periodic auto-reload operation with a registered
// one-cycle terminal-count pulse. All outputs come straight from flops
// (or are decoded from the state register), so no input reaches an output
// combinationally.

module cbd516_timer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             CDN,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             terminal_s;

  // A count of 0 or 1 is terminal: the timer never decrements through zero.
  function automatic logic is_terminal(input logic [WIDTH-1:0] cnt);
    is_terminal = (cnt[WIDTH-1:1] == {(WIDTH-1){1'b0}});
  endfunction

  // Terminal detection on the current count.
  always_comb begin
    terminal_s = is_terminal(q_q);
  end

  // Next-state logic: load beats start, start beats counting, otherwise hold.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rld_d   = rld_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;
    if (LD) begin
      rld_d   = D;
      q_d     = D;
      state_d = ST_IDLE;
    end else if (START) begin
      q_d     = rld_q;
      mode_d  = MODE;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (EN) begin
            if (terminal_s) begin
              tc_d = 1'b1;
              if (mode_q) begin
                q_d = rld_q;
              end else begin
                q_d     = {WIDTH{1'b0}};
                state_d = ST_DONE;
              end
            end else begin
              q_d = q_q - {{(WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            q_d = q_q;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          // Unreachable encoding: recover to a quiet idle state.
          state_d = ST_IDLE;
          q_d     = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, count, reload value, stored mode and terminal-count flops.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      state_q <= ST_IDLE;
      q_q     <= {WIDTH{1'b0}};
      rld_q   <= {WIDTH{1'b0}};
      mode_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rld_q   <= rld_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
    end
  end

  // Outputs are flop outputs or decodes of the state register.
  always_comb begin
    Q    = q_q;
    TC   = tc_q;
    BUSY = (state_q == ST_RUN);
    DONE = (state_q == ST_DONE);
  end

endmodule
